// File: rtl/hazard_stall_unit.sv
// RAW hazard detector beside decode: compares used rs1/rs2 against NSTAGE writer slices.
// Optional build macro FORWARD_EN: forward-select outputs, only load-use hazards stall.
module hazard_stall_unit #(
    parameter int NSTAGE = 3,
    parameter int REGW   = 5,
    parameter int CNTW   = 32,
    localparam int SELW  = $clog2(NSTAGE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            inst,
    input  logic [NSTAGE*REGW-1:0] stg_rd,
    input  logic [NSTAGE-1:0]      stg_we,
    input  logic [NSTAGE-1:0]      stg_load,
    input  logic                   flush,
    output logic                   stall,
    output logic                   bubble,
    output logic [SELW-1:0]        stall_cause,
    output logic [CNTW-1:0]        stall_cnt,
    output logic [SELW-1:0]        fwd_rs1,
    output logic [SELW-1:0]        fwd_rs2
);

    typedef enum logic {RUN, STALL} state_t;

    state_t          state;
    logic [SELW-1:0] cnt;
    logic [SELW-1:0] cause_q;

    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            hit1;
    logic            hit2;
    logic [SELW-1:0] sel1;
    logic [SELW-1:0] sel2;
    logic            match;
    logic [SELW-1:0] match_sel;
    logic [SELW-1:0] run_len;
    logic            stall_c;
    logic [SELW-1:0] cause_c;
    logic            unused_bits;

    assign rs1         = REGW'(inst[19:15]);
    assign rs2         = REGW'(inst[24:20]);
    assign unused_bits = ^{inst[31:25], inst[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // Scan from the farthest slice inward so the nearest match overwrites the rest.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (stg_we[k] && stg_rd[k*REGW +: REGW] != '0) begin
                if (use_rs1 && stg_rd[k*REGW +: REGW] == rs1) begin
                    hit1 = 1'b1;
                    sel1 = SELW'(k + 1);
                end
                if (use_rs2 && stg_rd[k*REGW +: REGW] == rs2) begin
                    hit2 = 1'b1;
                    sel2 = SELW'(k + 1);
                end
            end
        end
    end

`ifdef FORWARD_EN
    // Only a load sitting in the nearest slice cannot be forwarded in time.
    assign match     = stg_load[0] && ((hit1 && sel1 == SELW'(1)) || (hit2 && sel2 == SELW'(1)));
    assign match_sel = SELW'(1);
    assign run_len   = '0;
    assign fwd_rs1   = (hit1 && !stall_c) ? sel1 : '0;
    assign fwd_rs2   = (hit2 && !stall_c) ? sel2 : '0;
`else
    logic [SELW-1:0] near_sel;
    logic            unused_load;

    assign near_sel    = (hit1 && (!hit2 || sel1 <= sel2)) ? sel1 : sel2;
    assign match       = hit1 || hit2;
    assign match_sel   = near_sel;
    assign run_len     = SELW'(NSTAGE) - near_sel;
    assign fwd_rs1     = '0;
    assign fwd_rs2     = '0;
    assign unused_load = ^stg_load;
`endif

    always_comb begin
        stall_c = 1'b0;
        cause_c = '0;
        if (flush) begin
            stall_c = 1'b0;
        end else if (state == STALL) begin
            stall_c = 1'b1;
            cause_c = cause_q;
        end else if (match) begin
            stall_c = 1'b1;
            cause_c = match_sel;
        end
    end

    assign stall       = stall_c;
    assign bubble      = stall_c;
    assign stall_cause = cause_c;

    // run_len counts the stall cycles still owed after the detecting RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            cnt       <= '0;
            cause_q   <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall_c && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
            if (flush) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (match && run_len != '0) begin
                            state   <= STALL;
                            cnt     <= run_len;
                            cause_q <= match_sel;
                        end
                    end
                    STALL: begin
                        if (cnt == SELW'(1)) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - SELW'(1);
                        end
                    end
                    default: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Parametrised RAW hazard detector for the in-order RV32I pipeline. It sits beside the decode stage and compares the decode instruction's source registers against the destinations of NSTAGE downstream writer stages. It drives a counter-based stall/bubble FSM and keeps a stall-cycle performance counter. Successor to the fixed 3-stage detector: it adds arbitrary depth, full opcode decode, x0 exclusion, flush abort and optional forwarding.

Parameters:
NSTAGE, 3, number of downstream writer stages tracked (slice 0 = nearest, i.e. ID/EX)
REGW, 5, register index width
CNTW, 32, width of stall performance counter
SELW, $clog2(NSTAGE+1), width of stage-select outputs (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
inst  in  32  instruction currently in decode
stg_rd  in  NSTAGE*REGW  slice k = rd of instruction k+1 stages ahead
stg_we  in  NSTAGE  bit k = slice k writes the register file
stg_load  in  NSTAGE  bit k = slice k is a load (used only with FORWARD_EN)
flush  in  1  branch/jump redirect; kills decode instruction
stall  out  1  hold PC and IF/ID
bubble  out  1  insert NOP into ID/EX
stall_cause  out  SELW  k+1 of the conflicting slice; 0 = none
stall_cnt  out  CNTW  total stalled cycles since reset
fwd_rs1  out  SELW  forward source for rs1 (k+1), 0 = register file
fwd_rs2  out  SELW  forward source for rs2, 0 = register file

Behaviour:
- Source use by opcode: rs1 used for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111; rs2 used for 0110011, 0100011, 1100011; all other opcodes use neither.
- Slice k matches when stg_we[k]=1, rd_k!=0, and rd_k equals a used rs. The nearest match (smallest k) has priority.
- FSM states RUN and STALL, plus a down-counter cnt of width SELW.
- In RUN, a match at k drives stall=bubble=1 and stall_cause=k+1 combinationally in the same cycle.
  - L = NSTAGE-k-1 is computed. If L>0, load cnt=L and go to STALL. If L=0, stay in RUN.
- In STALL: stall=bubble=1 and stall_cause holds the registered value. Matching is ignored.
  - If cnt==1, go to RUN. Otherwise decrement cnt.
- Total stall for a match at k is exactly NSTAGE-k cycles. On return to RUN, the instruction is re-evaluated; the freed slices hold bubbles, so there is no further stall.
- flush=1 has priority over everything. It forces stall=bubble=0 and stall_cause=0 that cycle, and sets next state RUN with cnt=0. The stall_cnt increment is suppressed.
- stall_cnt increments in every cycle where stall=1 and saturates at all-ones.
- Reset (rst=0 on a rising edge, including mid-stall): state=RUN, cnt=0, stall_cnt=0. All outputs read 0 while the FSM is idle with no match.
- stall and bubble are always identical.

Optional Feature:
FORWARD_EN
- Defined:
  - A match against a non-load slice never stalls; fwd_rsX = k+1 of the nearest matching slice for that source.
  - A match where stg_load[0]=1 at k=0 is a load-use hazard: exactly 1 stall cycle. In that cycle fwd_rsX=0. In the next cycle the load is in slice 1 and fwd_rsX=2.
  - Loads at k>=1 forward with no stall.
- Undefined: stg_load is ignored, fwd_rs1 and fwd_rs2 are tied to 0, and stalling follows the base rules above.

Test Plan:
1. NSTAGE=3, slice0 rd=5, we=1; inst=0x00128333 (add x6,x5,x1) -> stall=1 for 3 cycles, stall_cause=1 throughout, stall_cnt=3, then stall=0.
2. Same inst, only slice2 rd=5, we=1 -> exactly 1 stall cycle, stall_cause=3, FSM stays in RUN, stall_cnt=1.
3. Slice0 rd=0, we=1, inst uses x0 as rs1 -> no stall. Then inst=lui x7 (0x000013B7) with slice0 rd matching bits 19:15 -> no stall.
4. Case 1, with flush=1 in stall cycle 2 -> stall=0 that cycle, RUN next, stall_cnt=1. Separately, rst=0 mid-stall -> all outputs and stall_cnt=0 next cycle.
5. FORWARD_EN, slice0 non-load rd=5 -> stall=0, fwd_rs1=1, fwd_rs2=0. Slice0 load rd=5 -> 1 stall with fwd_rs1=0, then fwd_rs1=2 and stall=0.
6. stall_cnt preset near max (CNTW=4, force 14 via 14 stall cycles), then 3 more stall cycles -> stall_cnt=15 and holds.
